// File: rtl/mem_initiator.sv
// Single-outstanding memory-bus initiator.
// Takes one upstream command, holds it on the native memory bus until the
// responder completes it or the wait counter expires, then holds the
// response until upstream accepts it.
//
// state | meaning
// IDLE  | no transaction; cmd_ready asserted
// REQ   | request on the bus, waiting for mem_ready or timeout
// RESP  | response held on rsp_* until rsp_ready
module mem_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Terminal count: the request is aborted after TIMEOUT cycles on the bus.
    localparam logic [7:0] WAIT_TC = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       wait_done;

    assign wait_done = (wait_cnt == WAIT_TC);
    assign cmd_ready = (state == IDLE) && !reset;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; mem_ready wins over a simultaneous timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = REQ;
            REQ:     if (mem_ready || wait_done) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request/response registers and wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= 8'd0;
            mem_valid <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        mem_addr  <= cmd_addr;
                        mem_wdata <= cmd_wdata;
                        mem_wstrb <= cmd_wstrb;
                        mem_valid <= 1'b1;
                        wait_cnt  <= 8'd0;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        rsp_rdata <= (mem_wstrb == 4'd0) ? mem_rdata : 32'd0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (wait_done) begin
                        mem_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255, legal range 1..255: cycles mem_valid is held without mem_ready before the request is aborted.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_addr  input  32  command address.
REQ-007 cmd_wdata  input  32  command write data.
REQ-008 cmd_wstrb  input  4  byte write strobes; 4'b0000 means read.
REQ-009 mem_valid  output  1  native memory-bus request valid.
REQ-010 mem_ready  input  1  responder completion; single-cycle pulse from the ready-combine logic.
REQ-011 mem_addr  output  32  request address.
REQ-012 mem_wdata  output  32  request write data.
REQ-013 mem_wstrb  output  4  request byte strobes.
REQ-014 mem_rdata  input  32  responder read data, valid in the mem_ready cycle.
REQ-015 rsp_valid  output  1  response available.
REQ-016 rsp_ready  input  1  upstream accepts the response.
REQ-017 rsp_rdata  output  32  captured read data.
REQ-018 rsp_err  output  1  request aborted by timeout.

Function
REQ-019 The FSM SHALL have three states: IDLE, REQ and RESP, encoded in a registered state variable.
REQ-020 cmd_ready SHALL equal (state==IDLE) && !reset, decoded combinationally.
REQ-021 In IDLE with cmd_valid=1, the block SHALL register cmd_addr, cmd_wdata and cmd_wstrb into mem_addr, mem_wdata and mem_wstrb, set mem_valid=1, clear the wait counter and enter REQ at the next edge.
REQ-022 In REQ, mem_valid, mem_addr, mem_wdata and mem_wstrb SHALL remain stable until the cycle after mem_ready or timeout.
REQ-023 In REQ with mem_ready=1, the next edge SHALL clear mem_valid, set rsp_rdata=(mem_wstrb==0 ? mem_rdata : 0), set rsp_err=0, set rsp_valid=1 and enter RESP.
REQ-024 In REQ with mem_ready=0, the 8-bit wait counter SHALL increment by one per cycle.
REQ-025 When the counter equals TIMEOUT-1 and mem_ready=0, the next edge SHALL clear mem_valid, set rsp_rdata=0, set rsp_err=1, set rsp_valid=1 and enter RESP.
REQ-026 mem_ready and timeout in the same cycle SHALL complete normally, with rsp_err=0.
REQ-027 mem_ready SHALL be ignored outside REQ.
REQ-028 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold until a cycle with rsp_ready=1; the next edge SHALL clear rsp_valid and enter IDLE.
REQ-029 cmd_valid SHALL be ignored outside IDLE; at most one transaction is outstanding.
REQ-030 Latency SHALL be exact: command accepted at edge N gives mem_valid=1 in cycle N+1; mem_ready in cycle M gives rsp_valid=1 in cycle M+1; rsp_ready in cycle K gives cmd_ready=1 in cycle K+1.
REQ-031 Between transactions, mem_addr, mem_wdata and mem_wstrb SHALL retain their last values; only mem_valid qualifies them.

Reset
REQ-032 While reset=1 at an edge, the block SHALL set state=IDLE, counter=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-033 Reset asserted during REQ or RESP SHALL drop the transaction with no response issued, and mem_valid SHALL be 0 from the following cycle.
REQ-034 cmd_ready SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.

Verification
REQ-035 Read: cmd addr=0x0000_0400, wstrb=0; mem_ready one cycle after mem_valid rises with rdata=0xDEADBEEF -> rsp_valid with rsp_rdata=0xDEADBEEF, rsp_err=0, per REQ-030 timing.
REQ-036 Write: wstrb=4'b0011, wdata=0x12345678, mem_ready after 3 wait cycles -> mem_* stable for 4 cycles, rsp_rdata=0, rsp_err=0.
REQ-037 Timeout: TIMEOUT=4, no mem_ready -> mem_valid high exactly 4 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-038 Race: TIMEOUT=4, mem_ready in the 4th mem_valid cycle -> rsp_err=0, with rdata captured.
REQ-039 Backpressure and reset: rsp_ready held 0 for 5 cycles -> rsp_* stable and cmd_ready=0; a second run with reset pulsed during REQ -> mem_valid=0 and rsp_valid=0 next cycle, then cmd_ready=1.
